// File: rtl/seq_tx_1010.sv
// Serial 1010-pattern transmitter: shifts a parallel pattern out MSB-first rep+1 times
// and counts the overlapping "1010" occurrences it emits.
module seq_tx_1010 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] rep,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] exp_hits
);

  localparam int unsigned BW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] rep_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [2:0]       hist;
  logic             last_bit;
  logic             hit;

  assign last_bit = (bit_cnt == '0);
  assign hit      = ({hist, shreg[WIDTH-1]} == 4'b1010);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; stop outranks end-of-stream
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEND;
      S_SEND: begin
        if (stop)                            state_nxt = S_IDLE;
        else if (last_bit && rep_cnt == '0)  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift datapath, repetition handling and saturating hit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      pat_q    <= '0;
      rep_cnt  <= '0;
      bit_cnt  <= '0;
      hist     <= '0;
      exp_hits <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg    <= pattern;
            pat_q    <= pattern;
            rep_cnt  <= rep;
            bit_cnt  <= BW'(WIDTH - 1);
            hist     <= '0;
            exp_hits <= '0;
          end
        end
        S_SEND: begin
          hist <= {hist[1:0], shreg[WIDTH-1]};
          if (hit && exp_hits != '1) exp_hits <= exp_hits + HIT_W'(1);
          if (last_bit && rep_cnt != '0) begin
            shreg   <= pat_q;
            rep_cnt <= rep_cnt - CNT_W'(1);
            bit_cnt <= BW'(WIDTH - 1);
          end else begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded straight from registered state
  assign x_valid = (state == S_SEND);
  assign x_out   = x_valid & shreg[WIDTH-1];
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_seq_tx_1010.sv
// Directed scoreboard bench for seq_tx_1010 (default widths plus a HIT_W=2 instance).
module tb_seq_tx_1010;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] rep = '0;
  logic       x_out, x_valid, busy, done;
  logic [7:0] exp_hits;
  logic       x_out2, x_valid2, busy2, done2;
  logic [1:0] exp_hits2;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_tx_1010 #(.WIDTH(8), .CNT_W(4), .HIT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern), .rep(rep),
    .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done), .exp_hits(exp_hits)
  );

  seq_tx_1010 #(.WIDTH(8), .CNT_W(4), .HIT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern), .rep(rep),
    .x_out(x_out2), .x_valid(x_valid2), .busy(busy2), .done(done2), .exp_hits(exp_hits2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference hit count over the first n bits of the stream, saturating at sat
  function automatic int count_hits(input logic bits[$], input int n, input int sat);
    logic [3:0] win = '0;
    int h = 0;
    for (int i = 0; i < n; i++) begin
      win = {win[2:0], bits[i]};
      if (i >= 3 && win == 4'b1010 && h < sat) h++;
    end
    return h;
  endfunction

  task automatic run(input logic [7:0] pat, input logic [3:0] r, input int stop_at,
                     input bit hold_start);
    logic bits[$];
    int total = (int'(r) + 1) * 8;
    int n;
    int hits, hits2;
    for (int p = 0; p <= int'(r); p++)
      for (int i = 7; i >= 0; i--) bits.push_back(pat[i]);
    n = (stop_at > 0) ? stop_at : total;
    for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
    hits  = count_hits(bits, n, 255);
    hits2 = count_hits(bits, n, 3);

    @(negedge clk);
    pattern = pat;
    rep     = r;
    start   = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (!hold_start) begin
        start   = 1'b0;
        pattern = 8'($urandom);
        rep     = 4'($urandom);
      end
      chk("x_valid", 32'(x_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (exp_q.size() == 0) chk("queue_underflow", 32'd1, 32'd0);
      else chk("x_out", 32'(x_out), 32'(exp_q.pop_front()));
      if (k == stop_at) stop = 1'b1;
    end

    if (stop_at > 0) begin
      @(negedge clk);
      stop = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_x_valid", 32'(x_valid), 32'd0);
      chk("abort_x_out", 32'(x_out), 32'd0);
      chk("abort_hits", 32'(exp_hits), 32'(hits));
      chk("abort_hits_sat", 32'(exp_hits2), 32'(hits2));
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
      end
    end else begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_x_valid", 32'(x_valid), 32'd0);
      chk("done_x_out", 32'(x_out), 32'd0);
      chk("hits", 32'(exp_hits), 32'(hits));
      chk("hits_sat", 32'(exp_hits2), 32'(hits2));
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("hits_hold", 32'(exp_hits), 32'(hits));
      if (hold_start) begin
        // start still high in IDLE: a second transfer must begin now
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_x_valid", 32'(x_valid), 32'd1);
        chk("restart_x_out", 32'(x_out), 32'(pat[7]));
        chk("restart_hits_cleared", 32'(exp_hits), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hits", 32'(exp_hits), 32'd0);
        @(negedge clk);
        rst = 1'b1;
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #1;
    chk("reset_x_out", 32'(x_out), 32'd0);
    chk("reset_x_valid", 32'(x_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hits", 32'(exp_hits), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    chk("idle_stop_ignored", 32'(busy), 32'd0);
    stop = 1'b0;

    run(8'hAA, 4'd0, 0, 1'b0);
    run(8'hAA, 4'd1, 0, 1'b0);
    run(8'h05, 4'd1, 0, 1'b0);
    run(8'hA0, 4'd1, 0, 1'b1);
    run(8'hAA, 4'd3, 5, 1'b0);
    run(8'h5A, 4'd2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
